// File: rtl/imm_decode_pkg.sv
// Shared types, opcode constants and parameter checks for the immediate decode pipeline.
// Optional compressed (RVC) decode is enabled by defining IMM_RVC_EN.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_CSR  = 3'd6,
    FMT_C    = 3'd7
  } imm_fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } occ_state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational immediate/format decoder for one instruction word.
// Compressed decode is compiled in only when IMM_RVC_EN is defined.
module imm_decode_comb
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output imm_fmt_t        fmt,
  output logic            illegal
);

  if (!xlen_legal(XLEN)) begin : g_xlen_check
    $error("imm_decode_comb: XLEN must be 32 or 64");
  end

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_csr, imm_shamt;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  // Casting a signed operand up to XLEN sign-extends; unsigned operands zero-extend.
  assign imm_i     = XLEN'($signed(instr[31:20]));
  assign imm_s     = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b     = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u     = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j     = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_csr   = XLEN'(instr[19:15]);
  assign imm_shamt = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);

`ifdef IMM_RVC_EN
  logic [XLEN-1:0] c_imm;
  logic            c_illegal;

  always_comb begin
    c_imm     = '0;
    c_illegal = 1'b0;
    case ({instr[1:0], instr[15:13]})
      5'b00_000: begin  // C.ADDI4SPN, all-zero nzuimm is reserved
        c_imm     = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b00});
        c_illegal = (instr[12:5] == 8'd0);
      end
      5'b00_010, 5'b00_110: c_imm = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
      5'b01_000, 5'b01_010: c_imm = XLEN'($signed({instr[12], instr[6:2]}));
      5'b01_001: begin  // C.JAL exists only on RV32; RV64 reuses the slot for C.ADDIW
        if (XLEN == 32)
          c_imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                                 instr[2], instr[11], instr[5:3], 1'b0}));
        else
          c_illegal = 1'b1;
      end
      5'b01_101:
        c_imm = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6], instr[7],
                               instr[2], instr[11], instr[5:3], 1'b0}));
      5'b01_011: begin
        if (instr[11:7] == 5'd2)
          c_imm = XLEN'($signed({instr[12], instr[4:3], instr[5], instr[2], instr[6], 4'b0}));
        else
          c_imm = XLEN'($signed({instr[12], instr[6:2], 12'b0}));
      end
      5'b01_110, 5'b01_111:
        c_imm = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0}));
      5'b10_010: c_imm = XLEN'({instr[3:2], instr[12], instr[6:4], 2'b00});
      5'b10_110: c_imm = XLEN'({instr[8:7], instr[12:9], 2'b00});
      default:   c_illegal = 1'b1;
    endcase
  end
`endif

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP_IMM: begin
          fmt = FMT_I;
          imm = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_shamt : imm_i;
        end
        OPC_LOAD, OPC_JALR: begin
          fmt = FMT_I;
          imm = imm_i;
        end
        OPC_STORE: begin
          fmt = FMT_S;
          imm = imm_s;
        end
        OPC_BRANCH: begin
          fmt = FMT_B;
          imm = imm_b;
        end
        OPC_LUI, OPC_AUIPC: begin
          fmt = FMT_U;
          imm = imm_u;
        end
        OPC_JAL: begin
          fmt = FMT_J;
          imm = imm_j;
        end
        OPC_SYSTEM: begin
          if (funct3[2]) begin
            fmt = FMT_CSR;
            imm = imm_csr;
          end
        end
        OPC_OP:  ;
        default: illegal = 1'b1;
      endcase
    end else begin
`ifdef IMM_RVC_EN
      if (c_illegal) begin
        illegal = 1'b1;
      end else begin
        fmt = FMT_C;
        imm = c_imm;
      end
`else
      illegal = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/imm_decode_pipe.sv
// Valid/ready buffered immediate decoder: one-cycle latency, FIFO order, 1 or 2 entries.
// Compressed decode follows the IMM_RVC_EN macro of imm_decode_comb.
module imm_decode_pipe
  import imm_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output imm_fmt_t        out_fmt,
  output logic            out_illegal
);

  if (SKID > 1) begin : g_skid_check
    $error("imm_decode_pipe: SKID must be 0 or 1");
  end

  logic [XLEN-1:0] dec_imm;
  imm_fmt_t        dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  occ_state_t      state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [XLEN-1:0] head_imm_q, head_imm_d, skid_imm_q, skid_imm_d;
  imm_fmt_t        head_fmt_q, head_fmt_d, skid_fmt_q, skid_fmt_d;
  logic            head_ill_q, head_ill_d, skid_ill_q, skid_ill_d;
  logic            in_fire, out_fire;

  // Without the skid entry a new word can only enter as the head leaves.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d    = state_q;
    head_imm_d = head_imm_q;
    head_fmt_d = head_fmt_q;
    head_ill_d = head_ill_q;
    skid_imm_d = skid_imm_q;
    skid_fmt_d = skid_fmt_q;
    skid_ill_d = skid_ill_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            head_imm_d = dec_imm;
            head_fmt_d = dec_fmt;
            head_ill_d = dec_illegal;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            head_imm_d = dec_imm;
            head_fmt_d = dec_fmt;
            head_ill_d = dec_illegal;
          end else if (in_fire) begin
            skid_imm_d = dec_imm;
            skid_fmt_d = dec_fmt;
            skid_ill_d = dec_illegal;
            state_d    = ST_TWO;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            head_imm_d = skid_imm_q;
            head_fmt_d = skid_fmt_q;
            head_ill_d = skid_ill_q;
            state_d    = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_TWO);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  // NOTE: both buffer entries are reset as well, so out_* read zero/NONE while rst_n is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      head_imm_q  <= '0;
      head_fmt_q  <= FMT_NONE;
      head_ill_q  <= 1'b0;
      skid_imm_q  <= '0;
      skid_fmt_q  <= FMT_NONE;
      skid_ill_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      head_imm_q  <= head_imm_d;
      head_fmt_q  <= head_fmt_d;
      head_ill_q  <= head_ill_d;
      skid_imm_q  <= skid_imm_d;
      skid_fmt_q  <= skid_fmt_d;
      skid_ill_q  <= skid_ill_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = head_imm_q;
  assign out_fmt     = head_fmt_q;
  assign out_illegal = head_ill_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Directed bench: RV32 with skid buffer (dut_a) and RV64 without skid buffer (dut_b).
`timescale 1ns/1ps
module tb_imm_decode_pipe;
  import imm_decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_instr, a_out_imm;
  imm_fmt_t    a_out_fmt;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_instr;
  logic [63:0] b_out_imm;
  imm_fmt_t    b_out_fmt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] W1 = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] W2 = 32'h0020_0093;  // addi x1,x0,2
  localparam logic [31:0] W3 = 32'h0030_0093;  // addi x1,x0,3

  imm_decode_pipe #(.XLEN(32), .SKID(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_imm(a_out_imm), .out_fmt(a_out_fmt), .out_illegal(a_out_illegal)
  );

  imm_decode_pipe #(.XLEN(64), .SKID(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_imm(b_out_imm), .out_fmt(b_out_fmt), .out_illegal(b_out_illegal)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_decode(input logic [31:0] instr, input logic [31:0] e_imm,
                          input imm_fmt_t e_fmt, input logic e_ill, input string tag);
    a_in_valid  = 1'b1;
    a_in_instr  = instr;
    a_out_ready = 1'b1;
    tick();
    a_in_valid = 1'b0;
    check({tag, ".valid"}, a_out_valid, 1);
    check({tag, ".imm"}, a_out_imm, e_imm);
    check({tag, ".fmt"}, a_out_fmt, e_fmt);
    check({tag, ".illegal"}, a_out_illegal, e_ill);
    tick();
    check({tag, ".drain"}, a_out_valid, 0);
  endtask

  task automatic b_decode(input logic [31:0] instr, input logic [63:0] e_imm,
                          input imm_fmt_t e_fmt, input string tag);
    b_in_valid  = 1'b1;
    b_in_instr  = instr;
    b_out_ready = 1'b1;
    tick();
    b_in_valid = 1'b0;
    check({tag, ".valid"}, b_out_valid, 1);
    check({tag, ".imm"}, b_out_imm, e_imm);
    check({tag, ".fmt"}, b_out_fmt, e_fmt);
    check({tag, ".illegal"}, b_out_illegal, 0);
    tick();
    check({tag, ".drain"}, b_out_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_flush = 1'b0; a_in_valid = 1'b0; a_in_instr = '0; a_out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_instr = '0; b_out_ready = 1'b0;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst.a_valid", a_out_valid, 0);
    check("rst.a_imm", a_out_imm, 0);
    check("rst.a_fmt", a_out_fmt, FMT_NONE);
    check("rst.a_illegal", a_out_illegal, 0);
    check("rst.b_valid", b_out_valid, 0);
    check("rst.b_imm", b_out_imm, 0);
    tick();
    tick();
    check("rst.a_valid_held", a_out_valid, 0);
    rst_n = 1'b1;
    tick();
    check("rst.a_in_ready", a_in_ready, 1);
    check("rst.b_in_ready", b_in_ready, 1);

    // RV32 decode vectors
    a_decode(32'hFFF0_0093, 32'hFFFF_FFFF, FMT_I,    1'b0, "s1.addi_m1");
    a_decode(32'h7FF1_2083, 32'h0000_07FF, FMT_I,    1'b0, "lw_2047");
    a_decode(32'h4030_D093, 32'h0000_0003, FMT_I,    1'b0, "srai_3");
    a_decode(32'hFE20_AE23, 32'hFFFF_FFFC, FMT_S,    1'b0, "sw_m4");
    a_decode(32'h0000_0463, 32'h0000_0008, FMT_B,    1'b0, "beq_p8");
    a_decode(32'hFE00_1FE3, 32'hFFFF_FFFE, FMT_B,    1'b0, "bne_m2");
    a_decode(32'h1234_5297, 32'h1234_5000, FMT_U,    1'b0, "auipc");
    a_decode(32'hFFDF_F0EF, 32'hFFFF_FFFC, FMT_J,    1'b0, "jal_m4");
    a_decode(32'h3002_D073, 32'h0000_0005, FMT_CSR,  1'b0, "csrrwi_5");
    a_decode(32'h0000_0073, 32'h0000_0000, FMT_NONE, 1'b0, "ecall");
    a_decode(32'h0031_00B3, 32'h0000_0000, FMT_NONE, 1'b0, "add");
    a_decode(32'h0000_007F, 32'h0000_0000, FMT_NONE, 1'b1, "s5.opc_7f");
    a_decode(32'hFFFF_FFFF, 32'h0000_0000, FMT_NONE, 1'b1, "opc_7f_ones");
    a_decode(32'h0000_0000, 32'h0000_0000, FMT_NONE, 1'b1, "c_zero");
`ifdef IMM_RVC_EN
    a_decode(32'h0000_157D, 32'hFFFF_FFFF, FMT_C,    1'b0, "s6.c_addi");
    a_decode(32'h0000_40C0, 32'h0000_0004, FMT_C,    1'b0, "c_lw_4");
`else
    a_decode(32'h0000_157D, 32'h0000_0000, FMT_NONE, 1'b1, "s6.c_addi");
    a_decode(32'h0000_40C0, 32'h0000_0000, FMT_NONE, 1'b1, "c_lw_4");
`endif

    // Skid buffer back-pressure: three words, consumer stalled
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_instr  = W1;
    check("s3.ready_empty", a_in_ready, 1);
    tick();
    check("s3.ready_one", a_in_ready, 1);
    check("s3.head_w1", a_out_imm, 1);
    a_in_instr = W2;
    tick();
    check("s3.ready_full", a_in_ready, 0);
    a_in_instr = W3;
    tick();
    check("s3.ready_stall", a_in_ready, 0);
    check("s3.stable_valid", a_out_valid, 1);
    check("s3.stable_imm", a_out_imm, 1);
    check("s3.stable_fmt", a_out_fmt, FMT_I);
    a_out_ready = 1'b1;
    tick();
    check("s3.out_w2", a_out_imm, 2);
    check("s3.ready_again", a_in_ready, 1);
    tick();
    a_in_valid = 1'b0;
    check("s3.out_w3", a_out_imm, 3);
    check("s3.out_w3_valid", a_out_valid, 1);
    tick();
    check("s3.empty", a_out_valid, 0);

    // Flush at full occupancy with a word presented
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_instr  = W1;
    tick();
    a_in_instr = W2;
    tick();
    check("s4.full", a_in_ready, 0);
    a_flush    = 1'b1;
    a_in_instr = W3;
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("s4.valid_after", a_out_valid, 0);
    check("s4.ready_after", a_in_ready, 1);
    a_out_ready = 1'b1;
    tick();
    tick();
    check("s4.no_leak", a_out_valid, 0);

    // Flush with one entry while the presented word would be accepted
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_instr  = W1;
    tick();
    a_flush    = 1'b1;
    a_in_instr = W2;
    check("s4b.ready_in_flush", a_in_ready, 1);
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    check("s4b.valid_after", a_out_valid, 0);
    tick();
    check("s4b.dropped", a_out_valid, 0);

    // Asynchronous reset with an entry buffered
    a_in_valid = 1'b1;
    a_in_instr = W3;
    tick();
    a_in_valid = 1'b0;
    check("rst2.buffered", a_out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst2.async_valid", a_out_valid, 0);
    check("rst2.async_imm", a_out_imm, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rst2.in_ready", a_in_ready, 1);
    check("rst2.still_empty", a_out_valid, 0);

    // RV64 decode vectors
    b_decode(32'h8000_00B7, 64'hFFFF_FFFF_8000_0000, FMT_U, "s2.lui64");
    b_decode(32'hFFF0_0093, 64'hFFFF_FFFF_FFFF_FFFF, FMT_I, "addi64_m1");
    b_decode(32'h0210_D093, 64'h0000_0000_0000_0021, FMT_I, "srli64_33");

    // No skid: in_ready follows out_ready combinationally, pass-through at full
    b_out_ready = 1'b0;
    b_in_valid  = 1'b1;
    b_in_instr  = W1;
    check("b.ready_empty", b_in_ready, 1);
    tick();
    b_in_instr = W2;
    check("b.ready_stall", b_in_ready, 0);
    check("b.head_w1", b_out_imm, 1);
    b_out_ready = 1'b1;
    #1;
    check("b.ready_comb", b_in_ready, 1);
    tick();
    check("b.full_valid", b_out_valid, 1);
    check("b.full_w2", b_out_imm, 2);
    b_in_valid = 1'b0;
    tick();
    check("b.empty", b_out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
